if_fetch_queue: RTL and testbench

Parametrised instruction-fetch unit replacing the single-register PC stage. It sequences the fetch PC with exception, jump and sequential priority, and issues requests to a synchronous instruction ROM with 1-cycle read latency. Returned instructions are buffered, together with their PCs, in a DEPTH-entry queue that decouples fetch from a stallable decode stage. Any redirect flushes the queue and discards the in-flight read.

---
 rtl/if_fetch_queue_pkg.sv | 22 ++
 rtl/if_fetch_fifo.sv | 93 +++++++++
 rtl/if_fetch_queue.sv | 156 +++++++++++++++
 tb/tb_if_fetch_queue.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch queue.
// Holds the reset level, the valid/enable levels, the sequential PC step and
// the default {inst, pc} queue-entry type.
`timescale 1ns/1ps
package if_fetch_queue_pkg;

    localparam logic RST_ACTIVE = 1'b0;
    localparam logic VALID      = 1'b1;
    localparam logic EN         = 1'b1;

    localparam int unsigned PC_INC = 4;

    localparam int unsigned FQ_ADDR_W = 32;
    localparam int unsigned FQ_INST_W = 32;

    // Default queue entry: fetched instruction plus the PC it came from
    typedef struct packed {
        logic [FQ_INST_W-1:0] inst;
        logic [FQ_ADDR_W-1:0] pc;
    } fq_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// DEPTH-entry synchronous FIFO with flush, push, pop and occupancy count.
// The head entry is presented combinationally; while empty, head_o holds the
// last head that was presented (zero after reset).
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   flush_i         empty the FIFO (overrides push/pop)
//   push_i, push_data_i  write one entry
//   pop_i           remove the head entry
//   head_o          head entry (or last head when empty)
//   count_o         number of valid entries, 0..DEPTH
//   empty_o         count_o == 0
`timescale 1ns/1ps
module if_fetch_fifo
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fq_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  entry_t                   push_data_i,
    input  logic                     pop_i,
    output entry_t                   head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    entry_t             hold_q, hold_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_c;
    logic               do_push_c;
    logic               do_pop_c;

    // Next-state for pointers, count and the held head
    always_comb begin
        full_c    = (count_q == CNT_W'(DEPTH));
        do_pop_c  = pop_i & (count_q != '0);
        // A full FIFO accepts a push only when the head leaves in the same cycle
        do_push_c = push_i & (~full_c | do_pop_c);

        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        hold_d    = (count_q != '0) ? mem_q[rd_ptr_q] : hold_q;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push_c) - CNT_W'(do_pop_c);
        end
    end

    // Control registers
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    // Storage
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (do_push_c && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : hold_q;
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch unit: sequences the fetch PC (exception > jump >
// sequential), issues reads to a 1-cycle-latency ROM and buffers returned
// instructions with their PCs in a DEPTH-entry queue feeding decode.
// Optional feature macro: IF_PERF_EN adds perf_fetch / perf_flush counters.
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   excpt, ejpc            exception redirect request and target
//   jCe, jAddr             jump/branch redirect request and target
//   rom_ce, rom_addr       ROM read enable (combinational) and address
//   rom_data               ROM data, valid the cycle after rom_ce
//   inst_valid, inst, inst_pc  queue head to decode
//   id_ready               decode accepts the head
//   perf_fetch, perf_flush (IF_PERF_EN only) issue and flush event counters
`timescale 1ns/1ps
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       INST_W   = 32,
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              excpt,
    input  logic [ADDR_W-1:0] ejpc,
    input  logic              jCe,
    input  logic [ADDR_W-1:0] jAddr,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_data,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              id_ready
`ifdef IF_PERF_EN
    ,
    output logic [31:0]       perf_fetch,
    output logic [31:0]       perf_flush
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    logic              running_q, running_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    logic              redirect_c;
    logic [ADDR_W-1:0] target_c;
    logic              issue_c;
    logic              push_c;
    logic              pop_c;
    logic              valid_c;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    entry_t            push_entry;
    entry_t            head_entry;

    // Redirect selection and credit-based issue
    always_comb begin
        redirect_c = excpt | jCe;
        target_c   = excpt ? ejpc : jAddr;
        // Queued entries plus the outstanding read must leave room for a new one
        issue_c    = running_q & ~redirect_c
                   & ((fifo_count + CNT_W'(inflight_q)) < CNT_W'(DEPTH));
        push_c     = inflight_q & ~redirect_c;
        valid_c    = ~fifo_empty & ~redirect_c;
    end

    assign pop_c = valid_c & id_ready;

    // Fetch sequencing next-state
    always_comb begin
        running_d     = EN;
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue_c;
        inflight_pc_d = inflight_pc_q;

        if (redirect_c) begin
            fetch_pc_d = target_c;
        end else if (issue_c) begin
            fetch_pc_d    = fetch_pc_q + ADDR_W'(PC_INC);
            inflight_pc_d = fetch_pc_q;
        end
    end

    // Fetch sequencing registers
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            running_q     <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            running_q     <= running_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    assign push_entry = '{inst: rom_data, pc: inflight_pc_q};

    if_fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_c),
        .push_i      (push_c),
        .push_data_i (push_entry),
        .pop_i       (pop_c),
        .head_o      (head_entry),
        .count_o     (fifo_count),
        .empty_o     (fifo_empty)
    );

    assign rom_ce     = issue_c;
    assign rom_addr   = fetch_pc_q;
    assign inst_valid = valid_c;
    assign inst       = head_entry.inst;
    assign inst_pc    = head_entry.pc;

`ifdef IF_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // A flush only counts when it actually discards queued or in-flight work
    always_comb begin
        perf_fetch_d = perf_fetch_q + 32'(issue_c);
        perf_flush_d = perf_flush_q + 32'(redirect_c & (~fifo_empty | inflight_q));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            perf_fetch_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios followed by a
// randomized phase, all compared against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_if_fetch_queue;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned INST_W   = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              excpt;
    logic [ADDR_W-1:0] ejpc;
    logic              jCe;
    logic [ADDR_W-1:0] jAddr;
    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_data;
    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              id_ready;
`ifdef IF_PERF_EN
    logic [31:0]       perf_fetch;
    logic [31:0]       perf_flush;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] romf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Synchronous ROM, one-cycle read latency
    always_ff @(posedge clk) begin
        if (rom_ce) rom_data <= romf(rom_addr);
    end

    if_fetch_queue #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .excpt      (excpt),
        .ejpc       (ejpc),
        .jCe        (jCe),
        .jAddr      (jAddr),
        .rom_ce     (rom_ce),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .id_ready   (id_ready)
`ifdef IF_PERF_EN
        ,
        .perf_fetch (perf_fetch),
        .perf_flush (perf_flush)
`endif
    );

    // Behavioural model: a queue of PCs awaiting decode plus one outstanding read
    logic        m_run;
    logic [31:0] m_fpc;
    logic        m_infl;
    logic [31:0] m_ipc;
    logic [31:0] m_q[$];
    logic [31:0] m_last_pc;
    logic [31:0] m_last_inst;
    logic [31:0] m_next_pc;
    int unsigned m_pf;
    int unsigned m_pfl;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run       = 1'b0;
        m_fpc       = RESET_PC;
        m_infl      = 1'b0;
        m_ipc       = '0;
        m_q.delete();
        m_last_pc   = '0;
        m_last_inst = '0;
        m_next_pc   = RESET_PC;
        m_pf        = 0;
        m_pfl       = 0;
    endtask

    // One clock cycle: drive inputs, compare at the falling edge, advance the model
    task automatic cycle(input logic rdy, input logic ex, input logic [31:0] ea,
                         input logic jc, input logic [31:0] ja);
        logic        redir;
        logic [31:0] tgt;
        logic        e_ce;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        id_ready = rdy;
        excpt    = ex;
        ejpc     = ea;
        jCe      = jc;
        jAddr    = ja;
        @(negedge clk);
        redir   = ex | jc;
        tgt     = ex ? ea : ja;
        e_ce    = m_run && !redir && (int'(m_q.size()) + int'(m_infl) < int'(DEPTH));
        e_valid = (m_q.size() > 0) && !redir;
        e_pc    = (m_q.size() > 0) ? m_q[0] : m_last_pc;
        e_inst  = (m_q.size() > 0) ? romf(m_q[0]) : m_last_inst;
        check("rom_ce",     64'(rom_ce),     64'(e_ce));
        check("rom_addr",   64'(rom_addr),   64'(m_fpc));
        check("inst_valid", 64'(inst_valid), 64'(e_valid));
        check("inst_pc",    64'(inst_pc),    64'(e_pc));
        check("inst",       64'(inst),       64'(e_inst));
        if (e_valid && rdy) begin
            check("stream_pc", 64'(inst_pc), 64'(m_next_pc));
            m_next_pc = m_next_pc + 32'd4;
        end
`ifdef IF_PERF_EN
        check("perf_fetch", 64'(perf_fetch), 64'(m_pf));
        check("perf_flush", 64'(perf_flush), 64'(m_pfl));
`endif
        if (m_q.size() > 0) begin
            m_last_pc   = m_q[0];
            m_last_inst = romf(m_q[0]);
        end
        if (redir) begin
            if (m_q.size() > 0 || m_infl) m_pfl++;
            m_q.delete();
            m_infl    = 1'b0;
            m_fpc     = tgt;
            m_next_pc = tgt;
        end else begin
            if (e_valid && rdy) void'(m_q.pop_front());
            if (m_infl) m_q.push_back(m_ipc);
            if (e_ce) begin
                m_ipc  = m_fpc;
                m_fpc  = m_fpc + 32'd4;
                m_infl = 1'b1;
                m_pf++;
            end else begin
                m_infl = 1'b0;
            end
        end
        m_run = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rom_ce"},     64'(rom_ce),     64'(0));
        check({tag, "_rom_addr"},   64'(rom_addr),   64'(RESET_PC));
        check({tag, "_inst_valid"}, 64'(inst_valid), 64'(0));
        check({tag, "_inst"},       64'(inst),       64'(0));
        check({tag, "_inst_pc"},    64'(inst_pc),    64'(0));
    endtask

    initial begin
        rst      = 1'b0;
        excpt    = 1'b0;
        ejpc     = '0;
        jCe      = 1'b0;
        jAddr    = '0;
        id_ready = 1'b0;
        model_reset();

        // Reset state
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Streaming with decode always ready
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, '0, 1'b0, '0);

        // Decode stall fills the queue, then drains without loss
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b0, '0);

        // Jump while the queue is full
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0, 1'b1, 32'h0000_0100);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b0, '0);

        // Exception and jump together: exception target wins
        cycle(1'b1, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0200);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, '0, 1'b0, '0);

        // PC wraps modulo 2^32
        cycle(1'b1, 1'b0, '0, 1'b1, 32'hFFFF_FFF8);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, '0, 1'b0, '0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        r_rdy;
            logic        r_ex;
            logic        r_jc;
            logic [31:0] r_ea;
            logic [31:0] r_ja;
            r_rdy = ($urandom_range(0, 99) < 70);
            r_ex  = ($urandom_range(0, 99) < 3);
            r_jc  = ($urandom_range(0, 99) < 6);
            r_ea  = $urandom() & 32'hFFFF_FFFC;
            r_ja  = $urandom() & 32'hFFFF_FFFC;
            cycle(r_rdy, r_ex, r_ea, r_jc, r_ja);
        end

        // Reset mid-stream with three entries queued
        cycle(1'b0, 1'b0, '0, 1'b1, 32'h0000_0040);
        for (int i = 0; i < 20 && m_q.size() != 3; i++) cycle(1'b0, 1'b0, '0, 1'b0, '0);
        n_checks++;
        if (m_q.size() != 3) begin
            n_errors++;
            $display("FAIL fill3_bound: queued %0d required 3", m_q.size());
        end
        rst = 1'b0;
        #1;
        check("midrst_rom_ce",     64'(rom_ce),     64'(0));
        check("midrst_inst_valid", 64'(inst_valid), 64'(0));
        check("midrst_rom_addr",   64'(rom_addr),   64'(RESET_PC));
        check("midrst_inst_pc",    64'(inst_pc),    64'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Ten sequential issues, then a redirect with a read in flight
        for (int i = 0; i < 40 && m_pf < 10; i++) cycle(1'b1, 1'b0, '0, 1'b0, '0);
        cycle(1'b1, 1'b0, '0, 1'b1, 32'h0000_0300);
`ifdef IF_PERF_EN
        check("perf_fetch_10", 64'(perf_fetch), 64'(10));
        check("perf_flush_1",  64'(perf_flush), 64'(1));
`endif
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, '0, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
